// File: rtl/alu_seq_display.sv
// Multi-cycle ALU (add, subtract, shift-add multiply, restoring divide) with a
// sequential double-dabble converter feeding active-low 7-segment digits.
module alu_seq_display #(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 3
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Init,
    input  logic [WIDTH-1:0]      A,
    input  logic [WIDTH-1:0]      B,
    input  logic [1:0]            Select,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Err,
    output logic                  Neg,
    output logic [2*WIDTH-1:0]    Sal,
    output logic [7*DIGITS-1:0]   Seg,
    output logic [6:0]            Seg_sign
);

    localparam int SW = 2 * WIDTH;
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(SW + 1);
    localparam int IW = $clog2(SW);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_CONV, S_DONE} state_t;

    state_t            state_reg, state_next;
    logic              init_q_reg;
    logic              start;
    logic [WIDTH-1:0]  a_reg, b_reg;
    logic [1:0]        sel_reg;
    logic [SW-1:0]     sal_reg;
    logic              err_reg, neg_reg;
    logic [CW-1:0]     cnt_reg;
    logic [BW-1:0]     work_reg, disp_reg;

    logic              busy_next, done_next;
    logic              calc_last, conv_last;
    logic [WIDTH:0]    add_sum;
    logic [WIDTH-1:0]  sub_ab, sub_ba;
    logic [WIDTH:0]    mul_sum;
    logic [SW-1:0]     mul_next;
    logic [WIDTH:0]    div_shift, div_diff;
    logic [SW-1:0]     div_next;
    logic [SW-1:0]     dval;
    logic [IW-1:0]     bit_idx;
    logic              conv_bit;
    logic [BW-1:0]     work_adj, work_shift;
    logic              unused_adj_msb;

    assign start = Init & ~init_q_reg;

    // Arithmetic steps; sal_reg doubles as the multiply/divide working register.
    assign add_sum   = {1'b0, a_reg} + {1'b0, b_reg};
    assign sub_ab    = a_reg - b_reg;
    assign sub_ba    = b_reg - a_reg;
    assign mul_sum   = {1'b0, sal_reg[SW-1:WIDTH]} + {1'b0, a_reg};
    assign mul_next  = sal_reg[0] ? {mul_sum, sal_reg[WIDTH-1:1]}
                                  : {1'b0, sal_reg[SW-1:1]};
    assign div_shift = {sal_reg[SW-1:WIDTH], sal_reg[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_reg};
    assign div_next  = div_diff[WIDTH]
                     ? {div_shift[WIDTH-1:0], sal_reg[WIDTH-2:0], 1'b0}
                     : {div_diff[WIDTH-1:0],  sal_reg[WIDTH-2:0], 1'b1};

    assign calc_last = ~sel_reg[1]
                     | (sel_reg == 2'b11 && b_reg == '0)
                     | (cnt_reg == CW'(WIDTH - 1));
    assign conv_last = (cnt_reg == CW'(SW - 1));

    // Divide shows only the quotient in decimal.
    assign dval     = (sel_reg == 2'b11) ? {{WIDTH{1'b0}}, sal_reg[WIDTH-1:0]} : sal_reg;
    assign bit_idx  = IW'(SW - 1 - int'(cnt_reg));
    assign conv_bit = dval[bit_idx];

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign work_adj[4*gi +: 4] = (work_reg[4*gi +: 4] >= 4'd5)
                                       ? work_reg[4*gi +: 4] + 4'd3
                                       : work_reg[4*gi +: 4];
        end
    endgenerate

    assign work_shift     = {work_adj[BW-2:0], conv_bit};
    assign unused_adj_msb = work_adj[BW-1];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        case (state_reg)
            S_IDLE: if (start) state_next = S_CALC;
            S_CALC: begin
                busy_next = 1'b1;
                if (calc_last) state_next = S_CONV;
            end
            S_CONV: begin
                busy_next = 1'b1;
                if (conv_last) state_next = S_DONE;
            end
            S_DONE: begin
                done_next = 1'b1;
                if (start) state_next = S_CALC;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            init_q_reg <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            sel_reg    <= '0;
            sal_reg    <= '0;
            err_reg    <= 1'b0;
            neg_reg    <= 1'b0;
            cnt_reg    <= '0;
            work_reg   <= '0;
            disp_reg   <= '0;
        end else begin
            init_q_reg <= Init;
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_reg   <= A;
                        b_reg   <= B;
                        sel_reg <= Select;
                        err_reg <= 1'b0;
                        neg_reg <= 1'b0;
                        cnt_reg <= '0;
                        // Preload the multiplier (multiply) or dividend (divide).
                        sal_reg <= (Select == 2'b10) ? {{WIDTH{1'b0}}, B}
                                                     : {{WIDTH{1'b0}}, A};
                    end
                end
                S_CALC: begin
                    case (sel_reg)
                        2'b00: sal_reg <= {{(WIDTH-1){1'b0}}, add_sum};
                        2'b01: begin
                            if (a_reg < b_reg) begin
                                sal_reg <= {{WIDTH{1'b0}}, sub_ba};
                                neg_reg <= 1'b1;
                            end else begin
                                sal_reg <= {{WIDTH{1'b0}}, sub_ab};
                            end
                        end
                        2'b10: sal_reg <= mul_next;
                        default: begin
                            if (b_reg == '0) begin
                                err_reg <= 1'b1;
                                sal_reg <= '0;
                            end else begin
                                sal_reg <= div_next;
                            end
                        end
                    endcase
                    if (calc_last) begin
                        cnt_reg  <= '0;
                        work_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_CONV: begin
                    work_reg <= work_shift;
                    cnt_reg  <= cnt_reg + 1'b1;
                    if (conv_last) disp_reg <= work_shift;
                end
                default: ;
            endcase
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // A digit is lit if it or any more significant digit is non-zero.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
            if (gi == 0) begin : g_lsd
                assign Seg[6:0] = seg7(disp_reg[3:0]);
            end else begin : g_msd
                assign Seg[7*gi +: 7] = (|disp_reg[BW-1:4*gi])
                                      ? seg7(disp_reg[4*gi +: 4]) : 7'b1111111;
            end
        end
    endgenerate

    assign Seg_sign = neg_reg ? 7'b0111111 : 7'b1111111;
    assign Busy     = busy_next;
    assign Done     = done_next;
    assign Err      = err_reg;
    assign Neg      = neg_reg;
    assign Sal      = sal_reg;

endmodule

// File: tb/tb_alu_seq_display.sv
// Randomised and directed bench for alu_seq_display against an arithmetic
// reference model (results, decimal display, latency and start handling).
module tb_alu_seq_display;

    localparam int W = 4;
    localparam int D = 3;

    logic             Clk = 1'b0;
    logic             Rst_n;
    logic             Init;
    logic [W-1:0]     A, B;
    logic [1:0]       Select;
    logic             Busy, Done, Err, Neg;
    logic [2*W-1:0]   Sal;
    logic [7*D-1:0]   Seg;
    logic [6:0]       Seg_sign;

    int checks = 0;
    int errors = 0;
    logic [7*D-1:0] model_seg;

    alu_seq_display #(.WIDTH(W), .DIGITS(D)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Init(Init), .A(A), .B(B), .Select(Select),
        .Busy(Busy), .Done(Done), .Err(Err), .Neg(Neg), .Sal(Sal),
        .Seg(Seg), .Seg_sign(Seg_sign)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: pat = 7'b1000000;  1: pat = 7'b1111001;  2: pat = 7'b0100100;
            3: pat = 7'b0110000;  4: pat = 7'b0011001;  5: pat = 7'b0010010;
            6: pat = 7'b0000010;  7: pat = 7'b1111000;  8: pat = 7'b0000000;
            default: pat = 7'b0010000;
        endcase
    endfunction

    // Decimal rendering of v with leading zeros blanked, digit 0 always lit.
    function automatic logic [7*D-1:0] exp_seg(input int v);
        logic [7*D-1:0] s;
        int p;
        p = 1;
        for (int i = 0; i < D; i++) begin
            if (i == 0 || v >= p) s[7*i +: 7] = pat((v / p) % 10);
            else                  s[7*i +: 7] = 7'b1111111;
            p = p * 10;
        end
        return s;
    endfunction

    task automatic run_op(input int a, input int b, input int sel,
                          input int inject_at, input bit hold, input string tag);
        int exp_sal, exp_val, lat, cycles;
        bit exp_neg, exp_err, fin;
        logic [7*D-1:0] es;
        exp_neg = 0;
        exp_err = 0;
        case (sel)
            0: begin exp_sal = a + b; exp_val = exp_sal; lat = 1; end
            1: begin
                exp_neg = (a < b);
                exp_sal = exp_neg ? b - a : a - b;
                exp_val = exp_sal; lat = 1;
            end
            2: begin exp_sal = a * b; exp_val = exp_sal; lat = W; end
            default: begin
                if (b == 0) begin
                    exp_err = 1; exp_sal = 0; exp_val = 0; lat = 1;
                end else begin
                    exp_sal = (a % b) * (1 << W) + a / b; exp_val = a / b; lat = W;
                end
            end
        endcase
        lat = lat + 2 * W;
        es  = exp_seg(exp_val);

        @(negedge Clk);
        Init = 1'b0;
        @(negedge Clk);
        A = W'(a); B = W'(b); Select = 2'(sel); Init = 1'b1;
        @(posedge Clk);
        #1;
        A = W'($urandom); B = W'($urandom); Select = 2'($urandom);
        if (!hold) Init = 1'b0;

        cycles = 0;
        fin = 0;
        while (!fin) begin
            if (Done === 1'b1) begin
                fin = 1;
            end else if (cycles >= 100) begin
                checks++; errors++;
                $display("FAIL %s timeout: Done never rose within %0d cycles", tag, cycles);
                fin = 1;
            end else begin
                checks++;
                if (Busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy cycle %0d: Busy=%b required 1", tag, cycles, Busy);
                end
                checks++;
                if (Seg !== model_seg) begin
                    errors++;
                    $display("FAIL %s display hold cycle %0d: Seg=%h required %h", tag, cycles, Seg, model_seg);
                end
                if (inject_at > 0 && cycles == inject_at) Init = 1'b1;
                @(posedge Clk);
                #1;
                cycles++;
            end
        end

        checks++;
        if (cycles !== lat) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles required %0d", tag, cycles, lat);
        end
        checks++;
        if (Sal !== (2*W)'(exp_sal)) begin
            errors++;
            $display("FAIL %s Sal: got %0d required %0d", tag, Sal, exp_sal);
        end
        checks++;
        if (Neg !== exp_neg || Err !== exp_err) begin
            errors++;
            $display("FAIL %s flags: Neg=%b Err=%b required Neg=%b Err=%b", tag, Neg, Err, exp_neg, exp_err);
        end
        checks++;
        if (Seg !== es) begin
            errors++;
            $display("FAIL %s Seg: got %h required %h", tag, Seg, es);
        end
        checks++;
        if (Seg_sign !== (exp_neg ? 7'b0111111 : 7'b1111111)) begin
            errors++;
            $display("FAIL %s Seg_sign: got %b required neg=%b", tag, Seg_sign, exp_neg);
        end
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL %s Busy in DONE: got %b required 0", tag, Busy);
        end
        model_seg = es;

        // With Init left high, no further operation may start.
        if (hold || inject_at > 0) begin
            for (int i = 0; i < 20; i++) begin
                @(posedge Clk);
                #1;
                checks++;
                if (Busy !== 1'b0 || Done !== 1'b1 || Sal !== (2*W)'(exp_sal)) begin
                    errors++;
                    $display("FAIL %s init-held cycle %0d: Busy=%b Done=%b Sal=%0d required 0 1 %0d",
                             tag, i, Busy, Done, Sal, exp_sal);
                end
            end
        end
        $display("op %-10s A=%0d B=%0d sel=%0d -> Sal=%0d Neg=%b Err=%b lat=%0d (exp Sal=%0d lat=%0d)",
                 tag, a, b, sel, Sal, Neg, Err, cycles, exp_sal, lat);
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (Sal !== '0 || Busy !== 1'b0 || Done !== 1'b0 || Err !== 1'b0 || Neg !== 1'b0) begin
            errors++;
            $display("FAIL %s outputs: Sal=%0d Busy=%b Done=%b Err=%b Neg=%b required all 0",
                     tag, Sal, Busy, Done, Err, Neg);
        end
        checks++;
        if (Seg !== {7'b1111111, 7'b1111111, 7'b1000000} || Seg_sign !== 7'b1111111) begin
            errors++;
            $display("FAIL %s display: Seg=%h Seg_sign=%b required blank-blank-0 and blank sign",
                     tag, Seg, Seg_sign);
        end
        model_seg = exp_seg(0);
    endtask

    task automatic test_reset();
        Rst_n = 1'b0; Init = 1'b0; A = '0; B = '0; Select = '0;
        repeat (3) @(posedge Clk);
        #1;
        check_reset_values("reset");
        $display("reset check done");
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    task automatic test_directed();
        run_op(7, 9, 0, 0, 0, "add");
        run_op(3, 9, 1, 0, 0, "sub_neg");
        run_op(15, 15, 2, 0, 1, "mul_hold");
        run_op(12, 11, 2, 0, 0, "restart");
        run_op(13, 4, 3, 0, 0, "div");
        run_op(13, 0, 3, 0, 0, "div_zero");
        run_op(15, 0, 0, 0, 0, "add_max");
        run_op(9, 9, 1, 0, 0, "sub_zero");
    endtask

    task automatic test_ignored_start();
        run_op(9, 14, 2, 8, 0, "ign_start");
    endtask

    task automatic test_reset_mid();
        @(negedge Clk);
        Init = 1'b0;
        @(negedge Clk);
        A = 4'd11; B = 4'd13; Select = 2'b10; Init = 1'b1;
        @(posedge Clk);
        #1;
        Init = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        check_reset_values("reset_mid");
        @(negedge Clk);
        Rst_n = 1'b1;
        $display("reset mid-multiply check done");
        run_op(11, 13, 2, 0, 0, "post_rst");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)), 0, 0, "random");
        end
    endtask

    initial begin
        model_seg = exp_seg(0);
        test_reset();
        test_directed();
        test_ignored_start();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
